// File: rtl/draw_pkg.sv
// Shared definitions for the plot/clear controller: default framebuffer
// geometry, the controller state type and the pixel address mapping.
package draw_pkg;

    localparam int DRAW_WIDTH_DEF  = 320;
    localparam int DRAW_HEIGHT_DEF = 240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_PLOT  = 2'd2
    } draw_state_e;

    // Row-major linear address of pixel (x, y); kept at 32 bits so callers
    // choose the final width without losing in-range results.
    function automatic logic [31:0] pixel_addr(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic [31:0] width);
        return x + y * width;
    endfunction

endpackage

// File: rtl/draw_plot_ctrl.sv
// Framebuffer write-side controller: on frame_start it sweeps the whole
// buffer with zeros (one write per cycle), then accepts plot requests and
// turns each in-range one into a single registered pixel write. Requests
// outside the framebuffer are dropped and counted.
module draw_plot_ctrl
    import draw_pkg::*;
#(
    parameter int DRAW_WIDTH  = DRAW_WIDTH_DEF,
    parameter int DRAW_HEIGHT = DRAW_HEIGHT_DEF,
    parameter int DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT,
    parameter int DRAW_ADDRW  = $clog2(DRAW_SIZE),
    parameter int DRAW_DATAW  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic                  plot_valid,
    output logic                  plot_ready,
    input  logic [9:0]            plot_x,
    input  logic [9:0]            plot_y,
    input  logic [DRAW_DATAW-1:0] plot_color,
    output logic                  draw_we,
    output logic [DRAW_ADDRW-1:0] draw_addr_write,
    output logic [DRAW_DATAW-1:0] draw_data_in,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           drop_cnt
);

    localparam logic [31:0]           WIDTH_U   = 32'(DRAW_WIDTH);
    localparam logic [31:0]           HEIGHT_U  = 32'(DRAW_HEIGHT);
    localparam logic [DRAW_ADDRW-1:0] LAST_ADDR = DRAW_ADDRW'(DRAW_SIZE - 1);

    draw_state_e           state_q;
    draw_state_e           state_d;
    logic [DRAW_ADDRW-1:0] clr_cnt;

    logic [31:0]           x_ext;
    logic [31:0]           y_ext;
    logic                  in_range;
    logic                  plot_accept;
    logic                  clear_last;
    logic [DRAW_ADDRW-1:0] plot_addr;

    // Write-port pipeline register (one stage after request acceptance)
    logic                  vld_p1;
    logic [DRAW_ADDRW-1:0] addr_p1;
    logic [DRAW_DATAW-1:0] data_p1;
    logic                  busy_q;
    logic                  done_q;
    logic [15:0]           drop_q;

    assign x_ext       = {22'd0, plot_x};
    assign y_ext       = {22'd0, plot_y};
    assign in_range    = (x_ext < WIDTH_U) && (y_ext < HEIGHT_U);
    assign plot_addr   = DRAW_ADDRW'(pixel_addr(x_ext, y_ext, WIDTH_U));
    assign clear_last  = (clr_cnt == LAST_ADDR);

    // frame_start takes priority over a simultaneous plot request
    assign plot_ready  = (state_q == ST_PLOT) && !frame_start;
    assign plot_accept = plot_valid && plot_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; frame_start is deliberately not looked at in CLEAR
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (frame_start) state_d = ST_CLEAR;
            ST_CLEAR: if (clear_last)  state_d = ST_PLOT;
            ST_PLOT:  if (frame_start) state_d = ST_CLEAR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Clear sweep counter, write port, status flags and drop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt <= '0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            vld_p1 <= 1'b0;
            done_q <= 1'b0;
            busy_q <= (state_d == ST_CLEAR);
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        clr_cnt <= '0;
                        vld_p1  <= 1'b1;
                        addr_p1 <= '0;
                        data_p1 <= '0;
                    end
                end
                ST_CLEAR: begin
                    // clr_cnt always equals the address currently presented
                    if (clear_last) begin
                        done_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        vld_p1  <= 1'b1;
                        addr_p1 <= clr_cnt + 1'b1;
                        data_p1 <= '0;
                    end
                end
                ST_PLOT: begin
                    if (frame_start) begin
                        clr_cnt <= '0;
                        vld_p1  <= 1'b1;
                        addr_p1 <= '0;
                        data_p1 <= '0;
                    end else if (plot_accept) begin
                        if (in_range) begin
                            vld_p1  <= 1'b1;
                            addr_p1 <= plot_addr;
                            data_p1 <= plot_color;
                        end else if (drop_q != 16'hFFFF) begin
                            drop_q <= drop_q + 16'd1;
                        end
                    end
                end
                default: begin
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    assign draw_we         = vld_p1;
    assign draw_addr_write = addr_p1;
    assign draw_data_in    = data_p1;
    assign busy            = busy_q;
    assign frame_done      = done_q;
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_draw_plot_ctrl.sv
// Bench for draw_plot_ctrl. Instance "a" (8x4) runs against a cycle model
// derived from elapsed time since frame_start; instance "b" (320 wide, 8 rows)
// covers literal address cases and reset during a long sweep.
module tb_draw_plot_ctrl;

    localparam int AW  = 8;
    localparam int AH  = 4;
    localparam int ASZ = AW * AH;
    localparam int BW  = 320;
    localparam int BH  = 8;
    localparam int BSZ = BW * BH;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // instance a
    logic       a_fs = 1'b0, a_pv = 1'b0, a_ready;
    logic [9:0] a_x = '0, a_y = '0;
    logic [0:0] a_col = '0;
    logic       a_we, a_busy, a_done;
    logic [4:0] a_addr;
    logic [0:0] a_data;
    logic [15:0] a_drop;

    // instance b
    logic        b_fs = 1'b0, b_pv = 1'b0, b_ready;
    logic [9:0]  b_x = '0, b_y = '0;
    logic [0:0]  b_col = '0;
    logic        b_we, b_busy, b_done;
    logic [11:0] b_addr;
    logic [0:0]  b_data;
    logic [15:0] b_drop;

    draw_plot_ctrl #(.DRAW_WIDTH(AW), .DRAW_HEIGHT(AH)) u_a (
        .clk(clk), .reset_n(reset_n), .frame_start(a_fs),
        .plot_valid(a_pv), .plot_ready(a_ready), .plot_x(a_x), .plot_y(a_y),
        .plot_color(a_col), .draw_we(a_we), .draw_addr_write(a_addr),
        .draw_data_in(a_data), .busy(a_busy), .frame_done(a_done),
        .drop_cnt(a_drop)
    );

    draw_plot_ctrl #(.DRAW_WIDTH(BW), .DRAW_HEIGHT(BH)) u_b (
        .clk(clk), .reset_n(reset_n), .frame_start(b_fs),
        .plot_valid(b_pv), .plot_ready(b_ready), .plot_x(b_x), .plot_y(b_y),
        .plot_color(b_col), .draw_we(b_we), .draw_addr_write(b_addr),
        .draw_data_in(b_data), .busy(b_busy), .frame_done(b_done),
        .drop_cnt(b_drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of instance a ----------------
    // mode: 0 idle, 1 clearing, 2 plotting. During clearing the expected
    // address is simply the number of edges since frame_start was taken.
    int          m_mode = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [0:0]  m_data = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_drop = '0;

    task automatic model_zero();
        m_mode = 0;
        m_we = 1'b0; m_addr = '0; m_data = '0;
        m_busy = 1'b0; m_done = 1'b0; m_drop = '0;
    endtask

    task automatic model_start();
        m_mode = 1;
        t0 = cyc;
        m_we = 1'b1; m_addr = '0; m_data = '0;
    endtask

    task automatic model_step();
        int k;
        cyc++;
        if (!reset_n) begin
            model_zero();
        end else begin
            m_we = 1'b0;
            m_done = 1'b0;
            if (m_mode == 0) begin
                if (a_fs) model_start();
            end else if (m_mode == 1) begin
                k = cyc - t0;
                if (k < ASZ) begin
                    m_we = 1'b1; m_addr = 5'(k); m_data = '0;
                end else begin
                    m_mode = 2; m_done = 1'b1;
                end
            end else begin
                if (a_fs) model_start();
                else if (a_pv) begin
                    if (int'(a_x) < AW && int'(a_y) < AH) begin
                        m_we = 1'b1;
                        m_addr = 5'(int'(a_x) + int'(a_y) * AW);
                        m_data = a_col;
                    end else if (m_drop != 16'hFFFF) begin
                        m_drop = m_drop + 16'd1;
                    end
                end
            end
            m_busy = (m_mode == 1);
        end
    endtask

    always @(negedge reset_n) model_zero();

    // compare process: model advances on the edge, DUT sampled 1 time unit later
    always @(posedge clk) begin
        model_step();
        #1;
        chk("a_we", 32'(a_we), 32'(m_we));
        chk("a_addr", 32'(a_addr), 32'(m_addr));
        chk("a_data", 32'(a_data), 32'(m_data));
        chk("a_busy", 32'(a_busy), 32'(m_busy));
        chk("a_done", 32'(a_done), 32'(m_done));
        chk("a_drop", 32'(a_drop), 32'(m_drop));
        chk("a_ready", 32'(a_ready), 32'((m_mode == 2) && !a_fs));
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        int wr_cnt, busy_cnt, done_cnt, done_at, rdy_busy, n;
        bit got;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_we", 32'(a_we), 0);
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_b_addr", 32'(b_addr), 0);
        chk("rst_b_ready", 32'(b_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // sweep on a with plot_valid held and a stray frame_start mid-sweep
        @(negedge clk);
        a_fs = 1'b1; a_pv = 1'b1; a_x = '0; a_y = '0; a_col = 1'b1;
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = -1; rdy_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (a_busy) begin
                busy_cnt++;
                if (a_ready) rdy_busy++;
                if (a_we) begin
                    chk("sweep_addr", 32'(a_addr), 32'(wr_cnt));
                    chk("sweep_data", 32'(a_data), 0);
                    wr_cnt++;
                end
            end
            if (a_done) begin done_cnt++; done_at = i; end
            @(negedge clk);
            a_fs = (i == 10);
        end
        a_fs = 1'b0;
        chk("sweep_writes", 32'(wr_cnt), 32);
        chk("sweep_busy_cycles", 32'(busy_cnt), 32);
        chk("sweep_done_pulses", 32'(done_cnt), 1);
        chk("sweep_done_at", 32'(done_at), 32);
        chk("sweep_ready_in_clear", 32'(rdy_busy), 0);

        // collision: frame_start beats plot_valid
        a_fs = 1'b1; a_pv = 1'b1; a_x = 10'd3; a_y = 10'd1;
        #1;
        chk("collide_ready", 32'(a_ready), 0);
        @(posedge clk); #1;
        chk("collide_we", 32'(a_we), 1);
        chk("collide_addr", 32'(a_addr), 0);
        chk("collide_busy", 32'(a_busy), 1);
        @(negedge clk);
        a_fs = 1'b0; a_pv = 1'b0;
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(posedge clk); #1;
            if (a_done) got = 1;
            n++;
        end
        chk("collide_done_seen", 32'(got), 1);

        // randomized traffic on a, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a_fs  = ($urandom_range(99, 0) == 0);
            a_pv  = ($urandom_range(9, 0) < 7);
            a_x   = 10'($urandom_range(11, 0));
            a_y   = 10'($urandom_range(5, 0));
            a_col = 1'($urandom_range(1, 0));
        end
        @(negedge clk);
        a_fs = 1'b0; a_pv = 1'b0;

        // b: full sweep of 2560 addresses
        b_fs = 1'b1;
        @(posedge clk); #1;
        busy_cnt = b_busy ? 1 : 0;
        chk("b_first_addr", 32'(b_addr), 0);
        @(negedge clk);
        b_fs = 1'b0;
        n = 0; got = 0;
        while (!got && n < BSZ + 20) begin
            @(posedge clk); #1;
            if (b_busy) busy_cnt++;
            if (b_done) got = 1;
            n++;
        end
        chk("b_done_seen", 32'(got), 1);
        chk("b_busy_cycles", 32'(busy_cnt), 32'(BSZ));

        // b: literal plot addresses and drops
        @(negedge clk);
        b_pv = 1'b1; b_x = 10'd5; b_y = 10'd2; b_col = 1'b1;
        #1;
        chk("b_ready_plot", 32'(b_ready), 1);
        @(posedge clk); #1;
        chk("b_plot_we", 32'(b_we), 1);
        chk("b_plot_addr", 32'(b_addr), 645);
        chk("b_plot_data", 32'(b_data), 1);
        @(negedge clk);
        b_x = 10'd319; b_y = 10'd7; b_col = 1'b0;
        @(posedge clk); #1;
        chk("b_corner_addr", 32'(b_addr), 2559);
        chk("b_corner_data", 32'(b_data), 0);
        @(negedge clk);
        b_x = 10'd320; b_y = 10'd0; b_col = 1'b1;
        @(posedge clk); #1;
        chk("b_drop1_we", 32'(b_we), 0);
        @(negedge clk);
        b_x = 10'd0; b_y = 10'd240;
        @(posedge clk); #1;
        chk("b_drop2_we", 32'(b_we), 0);
        @(negedge clk);
        b_pv = 1'b0;
        @(posedge clk); #1;
        chk("b_drop_cnt", 32'(b_drop), 2);
        chk("b_addr_hold", 32'(b_addr), 2559);

        // b: reset in the middle of a sweep
        @(negedge clk);
        b_fs = 1'b1;
        @(negedge clk);
        b_fs = 1'b0;
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            if (b_addr == 12'd100) got = 1;
            n++;
        end
        chk("b_reached_100", 32'(got), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("b_rst_we", 32'(b_we), 0);
        chk("b_rst_addr", 32'(b_addr), 0);
        chk("b_rst_busy", 32'(b_busy), 0);
        chk("b_rst_drop", 32'(b_drop), 0);
        chk("b_rst_ready", 32'(b_ready), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("b_idle_busy", 32'(b_busy), 0);
            chk("b_idle_we", 32'(b_we), 0);
        end
        @(negedge clk);
        b_fs = 1'b1;
        @(posedge clk); #1;
        chk("b_restart_we", 32'(b_we), 1);
        chk("b_restart_addr", 32'(b_addr), 0);
        chk("b_restart_busy", 32'(b_busy), 1);
        @(negedge clk);
        b_fs = 1'b0;
        @(posedge clk); #1;
        chk("b_restart_addr1", 32'(b_addr), 1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
